fp_divider: RTL and testbench
=============================

// Module: fp_divider
// PURPOSE
//   Iterative single-precision divider, the inverse operation to the FPU's multiply path: Y = A / B.
//   Uses the same float encoding rules as the FPU: denormal inputs are treated as zero,
//   underflow flushes to zero, and every NaN result is NAN_PATTERN.
//   Start/done handshake; a restoring divider produces one quotient bit per clock.
//   Sits beside the FPU behind the same operand registers and is muxed into the result path.
// PARAMETERS
//   NAN_PATTERN  32'hFFFFFFFF  value driven on y for every NaN result
// PORTS
//   clk           input   1   single clock; all state updates on posedge
//   rst           input   1   synchronous, active-high reset
//   start         input   1   request; accepted only on a posedge where busy==0
//   a             input   32  dividend, IEEE-754 single; sampled on the accept edge
//   b             input   32  divisor, IEEE-754 single; sampled on the accept edge
//   busy          output  1   high from the accept edge until the edge that raises done
//   done          output  1   one-cycle pulse; y and div_by_zero are valid from then on
//   y             output  32  quotient; holds its value until the next accept
//   div_by_zero   output  1   finite nonzero / zero; valid with done, held like y
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, y=32'h0, div_by_zero=0; all internal registers cleared.
//   Reset wins over start in the same cycle. Reset mid-operation aborts the operation, and no done
//   is produced for it.
//   A start while busy==1 is ignored and does not disturb the operation in flight.
//   States: IDLE -> UNPACK -> DIVIDE (27 cycles) -> ROUND -> DONE -> IDLE.
//     UNPACK: classify operands (zero: exp==0; inf: exp==255 & man==0; NaN: exp==255 & man!=0).
//       If the operation is special, load y and go straight to DONE.
//     Special cases (sign = sA^sB):
//       - either operand NaN, 0/0 or inf/inf -> NAN_PATTERN
//       - inf/x or x/0 -> signed inf; div_by_zero=1 only for x/0 with x finite
//       - 0/x or x/inf -> signed zero
//     Normal path: sigA={1,manA}, sigB={1,manB} (24b). Exponent e = expA - expB + 127, held as a
//       10-bit signed value.
//     DIVIDE: restoring division of sigA by sigB; 27 quotient bits q[26:0], MSB first.
//       q[26] is the integer bit. The remainder is kept in a 25-bit register.
//     ROUND:
//       - q[26]==1: sig=q[26:3], guard=q[2], sticky=|q[1:0] | (rem!=0).
//       - q[26]==0: sig=q[25:2], guard=q[1], sticky=q[0] | (rem!=0), and e=e-1.
//       - Round to nearest, ties to even: increment when guard & (sticky | sig[0]).
//       - If the increment carries out, sig=24'h800000 and e=e+1.
//       - e>=255 -> signed inf; e<=0 -> signed zero (flush). No flag is raised for either.
//     DONE: done=1 and busy=0 for one cycle, then IDLE. A start in the DONE cycle is not accepted.
//   Latency, counted from the accept edge to the edge that raises done:
//     normal 30 edges (1 UNPACK + 27 DIVIDE + 1 ROUND + 1 DONE); special 2 edges.
//   Outputs are registered only; there are no combinational paths from inputs to outputs.
// TESTING
//   1. a=40C00000 (6.0), b=40000000 (2.0) -> y=40400000, div_by_zero=0, done 30 edges after accept.
//   2. a=3F800000, b=40400000 (1/3) -> y=3EAAAAAB (RNE rounds up).
//      a=3F800000, b=3F800000 -> y=3F800000.
//   3. a=BF800000, b=00000000 -> y=FF800000, div_by_zero=1, done 2 edges after accept.
//      a=00000000, b=00000000 -> y=FFFFFFFF, div_by_zero=0.
//   4. a=7F800000, b=7F800000 -> y=FFFFFFFF.
//      a=7FC00000 (NaN), b=3F800000 -> y=FFFFFFFF.
//      a=40000000, b=FF800000 -> y=80000000.
//   5. a=7F000000, b=3E800000 -> y=7F800000 (overflow).
//      a=00800000, b=40000000 -> y=00000000 (underflow flushed).
//   6. rst pulsed on the 10th DIVIDE cycle -> busy=0, y=0 next cycle, no done.
//      A start during busy is ignored.
//      A fresh start of 6.0/2.0 after the reset still returns 40400000.

Source files
------------

// File: rtl/fp_divider.sv
// Iterative single-precision divider (Y = A / B): restoring division, one quotient bit per clock.
// Denormal inputs are treated as zero, underflow flushes to zero, every NaN result is NAN_PATTERN.
module fp_divider #(
   parameter logic [31:0] NAN_PATTERN = 32'hFFFF_FFFF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_y,
   output logic        o_div_by_zero
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_DIVIDE = 3'd2,
      S_ROUND  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic               r_sign;
   logic signed [9:0]  r_exp;
   logic [23:0]        r_sigb;
   logic [24:0]        r_rem;
   logic [26:0]        r_q;
   logic [4:0]         r_cnt;
   logic [31:0]        r_res_y;
   logic               r_res_dbz;
   logic               r_busy;
   logic               r_done;
   logic [31:0]        r_y;
   logic               r_dbz;

   logic               w_a_zero, w_a_inf, w_a_nan;
   logic               w_b_zero, w_b_inf, w_b_nan;
   logic               w_sign;
   logic               w_special;
   logic [31:0]        w_spec_y;
   logic               w_spec_dbz;

   logic               w_qbit;
   logic [24:0]        w_rem_sub;
   logic [24:0]        w_rem_nxt;

   logic [22:0]        w_man_pre;
   logic               w_guard;
   logic               w_sticky;
   logic               w_inc;
   logic signed [9:0]  w_exp_pre;
   logic signed [9:0]  w_exp_fin;
   logic [22:0]        w_man_fin;
   logic [31:0]        w_round_y;

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_y           = r_y;
   assign o_div_by_zero = r_dbz;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   w_state_nxt = i_start ? S_UNPACK : S_IDLE;
         S_UNPACK: w_state_nxt = w_special ? S_DONE : S_DIVIDE;
         S_DIVIDE: w_state_nxt = (r_cnt == 5'd26) ? S_ROUND : S_DIVIDE;
         S_ROUND:  w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Operand classification and special-case results.
   always_comb begin
      w_a_zero   = (r_a[30:23] == 8'h00);
      w_a_inf    = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
      w_a_nan    = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
      w_b_zero   = (r_b[30:23] == 8'h00);
      w_b_inf    = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
      w_b_nan    = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
      w_sign     = r_a[31] ^ r_b[31];
      w_special  = 1'b1;
      w_spec_y   = 32'h0000_0000;
      w_spec_dbz = 1'b0;
      if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
         w_spec_y = NAN_PATTERN;
      end else if (w_a_inf) begin
         w_spec_y = {w_sign, 8'hFF, 23'd0};
      end else if (w_b_zero) begin
         // a is finite and nonzero here: the only case that raises div_by_zero
         w_spec_y   = {w_sign, 8'hFF, 23'd0};
         w_spec_dbz = 1'b1;
      end else if (w_a_zero || w_b_inf) begin
         w_spec_y = {w_sign, 31'd0};
      end else begin
         w_special = 1'b0;
      end
   end

   // One restoring step: subtract the divisor when it fits.
   always_comb begin
      w_rem_sub = r_rem - {1'b0, r_sigb};
      w_qbit    = (r_rem >= {1'b0, r_sigb});
      if (w_qbit) begin
         w_rem_nxt = w_rem_sub;
      end else begin
         w_rem_nxt = r_rem;
      end
   end

   // Normalise, round to nearest even, and range-check the exponent.
   always_comb begin
      if (r_q[26]) begin
         w_man_pre = r_q[25:3];
         w_guard   = r_q[2];
         w_sticky  = (|r_q[1:0]) | (r_rem != 25'd0);
         w_exp_pre = r_exp;
      end else begin
         w_man_pre = r_q[24:2];
         w_guard   = r_q[1];
         w_sticky  = r_q[0] | (r_rem != 25'd0);
         w_exp_pre = r_exp - 10'sd1;
      end
      w_inc     = w_guard & (w_sticky | w_man_pre[0]);
      // an all-ones mantissa wraps to zero on increment, which is exactly 24'h800000
      w_man_fin = w_man_pre + {22'd0, w_inc};
      if (w_inc && (&w_man_pre)) begin
         w_exp_fin = w_exp_pre + 10'sd1;
      end else begin
         w_exp_fin = w_exp_pre;
      end
      if (w_exp_fin >= 10'sd255) begin
         w_round_y = {r_sign, 8'hFF, 23'd0};
      end else if (w_exp_fin <= 10'sd0) begin
         w_round_y = {r_sign, 31'd0};
      end else begin
         w_round_y = {r_sign, w_exp_fin[7:0], w_man_fin};
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a       <= 32'd0;
         r_b       <= 32'd0;
         r_sign    <= 1'b0;
         r_exp     <= 10'sd0;
         r_sigb    <= 24'd0;
         r_rem     <= 25'd0;
         r_q       <= 27'd0;
         r_cnt     <= 5'd0;
         r_res_y   <= 32'd0;
         r_res_dbz <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_y       <= 32'd0;
         r_dbz     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_a    <= i_a;
                  r_b    <= i_b;
                  r_busy <= 1'b1;
               end
            end
            S_UNPACK: begin
               r_sign    <= w_sign;
               r_res_y   <= w_spec_y;
               r_res_dbz <= w_spec_dbz;
               r_exp     <= $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]}) + 10'sd127;
               r_sigb    <= {1'b1, r_b[22:0]};
               r_rem     <= {2'b01, r_a[22:0]};
               r_q       <= 27'd0;
               r_cnt     <= 5'd0;
            end
            S_DIVIDE: begin
               r_q   <= {r_q[25:0], w_qbit};
               r_rem <= w_rem_nxt << 1;
               r_cnt <= r_cnt + 5'd1;
            end
            S_ROUND: begin
               r_res_y   <= w_round_y;
               r_res_dbz <= 1'b0;
            end
            S_DONE: begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_y    <= r_res_y;
               r_dbz  <= r_res_dbz;
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: vector table with a scoreboard queue, plus
// hand-written reset-abort and start-while-busy sequences.
module tb_fp_divider;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic        dbz;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] y;
      logic        dbz;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        busy;
   logic        done;
   logic [31:0] y;
   logic        dbz;

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t sb[$];
   vec_t vecs[16];

   fp_divider #(.NAN_PATTERN(32'hFFFF_FFFF)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_a          (a_in),
      .i_b          (b_in),
      .o_busy       (busy),
      .o_done       (done),
      .o_y          (y),
      .o_div_by_zero(dbz)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one operation; optionally fire a stray start while busy.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ey,
                         input logic edbz, input int elat, input bit inject);
      exp_t e;
      exp_t got;
      int   lat;
      @(negedge clk);
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      e.y = ey; e.dbz = edbz; e.lat = elat;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      a_in  = 32'h0;
      b_in  = 32'h0;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      lat = 0;
      while (!done && lat < 100) begin
         if (inject && lat == 5) begin
            start = 1'b1;
            a_in  = 32'h4000_0000;
            b_in  = 32'h3F80_0000;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      got = sb.pop_front();
      check("latency", lat, got.lat);
      check("y", y, got.y);
      check("div_by_zero", {31'd0, dbz}, {31'd0, got.dbz});
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, done}, 32'd0);
   endtask

   initial begin
      int done_seen;
      vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 30};
      vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 30};
      vecs[2]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 30};
      vecs[3]  = '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 2};
      vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 2};
      vecs[5]  = '{32'h7F80_0000, 32'h7F80_0000, 32'hFFFF_FFFF, 1'b0, 2};
      vecs[6]  = '{32'h7FC0_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 1'b0, 2};
      vecs[7]  = '{32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, 2};
      vecs[8]  = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0, 30};
      vecs[9]  = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 30};
      vecs[10] = '{32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b0, 30};
      vecs[11] = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 2};
      vecs[12] = '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 2};
      vecs[13] = '{32'h0040_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 2};
      vecs[14] = '{32'h7F80_0000, 32'h0000_0000, 32'hFF80_0000 ^ 32'h8000_0000, 1'b0, 2};
      vecs[15] = '{32'h4040_0000, 32'hBF80_0000, 32'hC040_0000, 1'b0, 30};

      rst   = 1'b1;
      start = 1'b1;
      a_in  = 32'h40C0_0000;
      b_in  = 32'h4000_0000;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_y", y, 32'd0);
      check("reset_dbz", {31'd0, dbz}, 32'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].dbz, vecs[i].lat, 1'b0);
      end

      // stray start in flight must not disturb 1/3
      run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 30, 1'b1);

      // reset during DIVIDE aborts with no done
      @(negedge clk);
      start = 1'b1;
      a_in  = 32'h40C0_0000;
      b_in  = 32'h4000_0000;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_y", y, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      check("abort_no_done", done_seen, 0);

      run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 30, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
